adc_scan_scheduler: RTL and testbench

- Avalon-MM master that sequences the on-chip ADC sequencer slave.
- After enable, performs one configuration write, then periodically scans the enabled channel slots and reads each one.
- Presents each result as a tagged sample strobe to downstream game logic (paddle/joystick filters).
- Adds a programmable frame period, a per-frame channel mask, a waitrequest timeout and graceful stop.

---
 rtl/adc_scan_scheduler.sv | 225 ++++++++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Avalon-MM master that configures the ADC sequencer, then scans the masked
// channel slots once per programmable frame and emits tagged sample strobes.
module adc_scan_scheduler #(
    parameter int          NUM_CH     = 6,
    parameter int          DATA_W     = 12,
    parameter int          ADDR_W     = 3,
    parameter logic [31:0] CTRL_VALUE = 32'h1,
    parameter int          PERIOD_W   = 16,
    parameter int          TIMEOUT    = 255
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                enable,
    input  logic [NUM_CH-1:0]   ch_mask,
    input  logic [PERIOD_W-1:0] period,
    output logic [ADDR_W-1:0]   avm_address,
    output logic                avm_read,
    output logic                avm_write,
    output logic [31:0]         avm_writedata,
    input  logic [31:0]         avm_readdata,
    input  logic                avm_waitrequest,
    output logic [DATA_W-1:0]   sample_data,
    output logic [ADDR_W-1:0]   sample_ch,
    output logic                sample_valid,
    output logic                frame_done,
    output logic                busy,
    output logic                err_timeout
);
    localparam int STALL_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_FRAME_START, S_READ, S_SKIP, S_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic                read_q, read_d;
    logic                write_q, write_d;
    logic [31:0]         wdata_q, wdata_d;
    logic [NUM_CH-1:0]   mask_q, mask_d;
    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic [STALL_W-1:0]  stall_q, stall_d;
    logic [DATA_W-1:0]   sdata_q, sdata_d;
    logic [ADDR_W-1:0]   sch_q, sch_d;
    logic                svalid_q, svalid_d;
    logic                fdone_q, fdone_d;
    logic                busy_q, busy_d;
    logic                err_q, err_d;

    logic [ADDR_W:0]     first_s, next_s;
    logic                done_s, tmo_s, period_hit_s;
    logic                unused_rdata_s;

    // Lowest set mask bit at or above start; MSB of the result flags a hit.
    function automatic logic [ADDR_W:0] find_slot(input logic [NUM_CH-1:0] m, input int start);
        logic [ADDR_W:0] r;
        r = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (m[i] && (i >= start)) begin
                r = {1'b1, ADDR_W'(i)};
            end
        end
        return r;
    endfunction

    assign unused_rdata_s = ^avm_readdata[31:DATA_W];
    assign first_s        = find_slot(ch_mask, 0);
    assign next_s         = find_slot(mask_q, int'(addr_q) + 1);
    assign done_s         = (read_q | write_q) & ~avm_waitrequest;
    assign tmo_s          = (read_q | write_q) & avm_waitrequest & (stall_q == STALL_W'(TIMEOUT - 1));
    // The counter reads k in the k-th cycle after FRAME_START, so the exit test is cnt+1 >= period.
    assign period_hit_s   = ({1'b0, cnt_q} + {{PERIOD_W{1'b0}}, 1'b1}) >= {1'b0, period};

    // Next-state and next-output logic.
    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        read_d   = read_q;
        write_d  = write_q;
        wdata_d  = wdata_q;
        mask_d   = mask_q;
        cnt_d    = (&cnt_q) ? cnt_q : cnt_q + PERIOD_W'(1);
        stall_d  = stall_q;
        sdata_d  = sdata_q;
        sch_d    = sch_q;
        svalid_d = 1'b0;
        fdone_d  = 1'b0;
        err_d    = err_q;
        case (state_q)
            S_IDLE: begin
                if (enable) begin
                    state_d = S_CFG;
                    write_d = 1'b1;
                    addr_d  = '0;
                    wdata_d = CTRL_VALUE;
                    stall_d = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_CFG: begin
                if (done_s || tmo_s) begin
                    write_d = 1'b0;
                    stall_d = '0;
                    err_d   = err_q | tmo_s;
                    state_d = enable ? S_FRAME_START : S_IDLE;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            S_FRAME_START: begin
                mask_d  = ch_mask;
                cnt_d   = PERIOD_W'(1);
                stall_d = '0;
                if (first_s[ADDR_W]) begin
                    read_d  = 1'b1;
                    addr_d  = first_s[ADDR_W-1:0];
                    state_d = S_READ;
                end else begin
                    fdone_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_READ: begin
                if (done_s) begin
                    sdata_d  = avm_readdata[DATA_W-1:0];
                    sch_d    = addr_q;
                    svalid_d = 1'b1;
                    stall_d  = '0;
                    if (!enable) begin
                        read_d  = 1'b0;
                        state_d = S_IDLE;
                    end else if (next_s[ADDR_W]) begin
                        addr_d = next_s[ADDR_W-1:0];
                    end else begin
                        read_d  = 1'b0;
                        fdone_d = 1'b1;
                        state_d = S_WAIT;
                    end
                end else if (tmo_s) begin
                    read_d  = 1'b0;
                    err_d   = 1'b1;
                    stall_d = '0;
                    state_d = S_SKIP;
                end else begin
                    stall_d = stall_q + STALL_W'(1);
                end
            end
            // One idle bus cycle after an abandoned read, then carry on with the scan.
            S_SKIP: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (next_s[ADDR_W]) begin
                    read_d  = 1'b1;
                    addr_d  = next_s[ADDR_W-1:0];
                    state_d = S_READ;
                end else begin
                    fdone_d = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!enable) begin
                    state_d = S_IDLE;
                end else if (period_hit_s) begin
                    state_d = S_FRAME_START;
                end else begin
                    state_d = S_WAIT;
                end
            end
            default: begin
                state_d = S_IDLE;
                read_d  = 1'b0;
                write_d = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            read_q   <= 1'b0;
            write_q  <= 1'b0;
            wdata_q  <= 32'h0;
            mask_q   <= '0;
            cnt_q    <= '0;
            stall_q  <= '0;
            sdata_q  <= '0;
            sch_q    <= '0;
            svalid_q <= 1'b0;
            fdone_q  <= 1'b0;
            busy_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            read_q   <= read_d;
            write_q  <= write_d;
            wdata_q  <= wdata_d;
            mask_q   <= mask_d;
            cnt_q    <= cnt_d;
            stall_q  <= stall_d;
            sdata_q  <= sdata_d;
            sch_q    <= sch_d;
            svalid_q <= svalid_d;
            fdone_q  <= fdone_d;
            busy_q   <= busy_d;
            err_q    <= err_d;
        end
    end

    assign avm_address   = addr_q;
    assign avm_read      = read_q;
    assign avm_write     = write_q;
    assign avm_writedata = wdata_q;
    assign sample_data   = sdata_q;
    assign sample_ch     = sch_q;
    assign sample_valid  = svalid_q;
    assign frame_done    = fdone_q;
    assign busy          = busy_q;
    assign err_timeout   = err_q;
endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Directed bench for adc_scan_scheduler: table of scan scenarios plus
// hand-written timeout, stop/re-enable and async-reset sequences.
module tb_adc_scan_scheduler;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        enable = 1'b0;
    logic [5:0]  ch_mask = 6'h0;
    logic [15:0] period = 16'd0;
    logic [2:0]  avm_address;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic [31:0] avm_readdata = 32'h0;
    logic        avm_waitrequest = 1'b0;
    logic [11:0] sample_data;
    logic [2:0]  sample_ch;
    logic        sample_valid, frame_done, busy, err_timeout;

    adc_scan_scheduler #(.TIMEOUT(8)) dut (
        .clk(clk), .reset(reset), .enable(enable), .ch_mask(ch_mask), .period(period),
        .avm_address(avm_address), .avm_read(avm_read), .avm_write(avm_write),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
        .avm_waitrequest(avm_waitrequest), .sample_data(sample_data), .sample_ch(sample_ch),
        .sample_valid(sample_valid), .frame_done(frame_done), .busy(busy),
        .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Slave model knobs
    int ws = 0;
    int stuck_addr = -1;
    int slow_addr = -1;
    int slow_ws = 0;

    // Monitor records
    int samp_ch[$], samp_dat[$], samp_cyc[$], fd_cyc[$];
    int wr_addr[$], wr_dat[$], rd_addr[$], runs[$], rise[$];
    logic [7:0] saw_rd;
    int run = 0, viol = 0, wcnt = 0;
    bit req, wait_now, prev_req, prev_wait, prev_read;
    logic [2:0] prev_addr;

    task automatic clear_mon();
        samp_ch.delete(); samp_dat.delete(); samp_cyc.delete(); fd_cyc.delete();
        wr_addr.delete(); wr_dat.delete(); rd_addr.delete(); runs.delete(); rise.delete();
        saw_rd = 8'h0;
        run = 0;
    endtask

    // Avalon slave and bus monitor, evaluated on the falling edge.
    always @(negedge clk) begin
        if (reset) begin
            avm_waitrequest = 1'b0;
            wcnt = 0; prev_req = 1'b0; prev_wait = 1'b0; prev_read = 1'b0;
        end else begin
            req = avm_read | avm_write;
            if (avm_read && avm_write) viol++;
            if (prev_req && prev_wait && req && avm_address != prev_addr) viol++;
            wait_now = 1'b0;
            if (req) begin
                if (avm_read && int'(avm_address) == stuck_addr) wait_now = 1'b1;
                else if (avm_read && int'(avm_address) == slow_addr) wait_now = (wcnt < slow_ws);
                else wait_now = (wcnt < ws);
            end
            avm_waitrequest = wait_now;
            avm_readdata = wait_now ? 32'hDEAD0000 : (32'h100 + 32'(avm_address));
            wcnt = (req && wait_now) ? wcnt + 1 : 0;
            if (req && !wait_now) begin
                if (avm_write) begin wr_addr.push_back(int'(avm_address)); wr_dat.push_back(int'(avm_writedata)); end
                else rd_addr.push_back(int'(avm_address));
            end
            if (avm_read) saw_rd[avm_address] = 1'b1;
            if (avm_read && !prev_read) rise.push_back(cyc);
            if (avm_read) run++;
            else if (run > 0) begin runs.push_back(run); run = 0; end
            if (sample_valid) begin
                samp_ch.push_back(int'(sample_ch)); samp_dat.push_back(int'(sample_data)); samp_cyc.push_back(cyc);
            end
            if (frame_done) fd_cyc.push_back(cyc);
            prev_req = req; prev_wait = wait_now; prev_read = avm_read; prev_addr = avm_address;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        enable = 1'b0;
        repeat (2) step();
        reset = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int k = 0; k < budget && fd_cyc.size() < n; k++) step();
        check("frame_done_within_budget", 64'(fd_cyc.size() >= n), 64'd1);
    endtask

    function automatic int frame1_count();
        int c = 0;
        for (int i = 0; i < samp_cyc.size(); i++) if (fd_cyc.size() > 0 && samp_cyc[i] <= fd_cyc[0]) c++;
        return c;
    endfunction

    typedef struct {
        logic [5:0]  mask;
        logic [15:0] period;
        int          ws;
        int          exp_n;
        logic [23:0] exp_chs;   // i-th sample channel in nibble i
        int          exp_space;
        int          exp_run;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int n1, ec;
        vecs[0] = '{6'h3F,    16'd100, 2, 6, 24'h543210, 100, 18};
        vecs[1] = '{6'b100101, 16'd0,  0, 3, 24'h000520, 5,   3};
        vecs[2] = '{6'h00,    16'd10,  0, 0, 24'h000000, 10,  0};
        vecs[3] = '{6'h10,    16'd1,   1, 1, 24'h000004, 4,   2};
        vecs[4] = '{6'h3F,    16'd5,   0, 6, 24'h543210, 8,   6};
        vecs[5] = '{6'h21,    16'd20,  3, 2, 24'h000050, 20,  8};

        repeat (2) step();
        check("rst_read", 64'(avm_read), 64'd0);
        check("rst_write", 64'(avm_write), 64'd0);
        check("rst_addr", 64'(avm_address), 64'd0);
        check("rst_wdata", 64'(avm_writedata), 64'd0);
        check("rst_sdata", 64'(sample_data), 64'd0);
        check("rst_sch", 64'(sample_ch), 64'd0);
        check("rst_svalid", 64'(sample_valid), 64'd0);
        check("rst_fdone", 64'(frame_done), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_err", 64'(err_timeout), 64'd0);

        for (int v = 0; v < 6; v++) begin
            ws = vecs[v].ws; stuck_addr = -1; slow_addr = -1;
            ch_mask = vecs[v].mask; period = vecs[v].period;
            do_reset();
            clear_mon();
            enable = 1'b1;
            wait_frames(2, 1000);
            check($sformatf("v%0d_wr_count", v), 64'(wr_addr.size()), 64'd1);
            if (wr_addr.size() > 0) begin
                check($sformatf("v%0d_wr_addr", v), 64'(wr_addr[0]), 64'd0);
                check($sformatf("v%0d_wr_data", v), 64'(wr_dat[0]), 64'd1);
            end
            if (fd_cyc.size() >= 2) begin
                n1 = frame1_count();
                check($sformatf("v%0d_nsamp", v), 64'(n1), 64'(vecs[v].exp_n));
                for (int i = 0; i < vecs[v].exp_n && i < n1; i++) begin
                    ec = int'(vecs[v].exp_chs[4*i +: 4]);
                    check($sformatf("v%0d_ch%0d", v, i), 64'(samp_ch[i]), 64'(ec));
                    check($sformatf("v%0d_data%0d", v, i), 64'(samp_dat[i]), 64'(32'h100 + ec));
                end
                check($sformatf("v%0d_fd_space", v), 64'(fd_cyc[1] - fd_cyc[0]), 64'(vecs[v].exp_space));
                if (vecs[v].exp_n > 0 && rise.size() >= 2)
                    check($sformatf("v%0d_start_space", v), 64'(rise[1] - rise[0]), 64'(vecs[v].exp_space));
                check($sformatf("v%0d_run", v), 64'(runs.size() > 0 ? runs[0] : 0), 64'(vecs[v].exp_run));
            end
            check($sformatf("v%0d_busy", v), 64'(busy), 64'd1);
            check($sformatf("v%0d_err", v), 64'(err_timeout), 64'd0);
            if (vecs[v].exp_n == 0) check($sformatf("v%0d_no_reads", v), 64'(saw_rd), 64'd0);
        end

        // Timeout: slot 3 never answers.
        ws = 0; stuck_addr = 3; slow_addr = -1;
        ch_mask = 6'h0F; period = 16'd40;
        do_reset();
        clear_mon();
        enable = 1'b1;
        wait_frames(1, 200);
        check("tmo_err_set", 64'(err_timeout), 64'd1);
        if (fd_cyc.size() >= 1) begin
            n1 = frame1_count();
            check("tmo_nsamp", 64'(n1), 64'd3);
            for (int i = 0; i < 3 && i < n1; i++) check($sformatf("tmo_ch%0d", i), 64'(samp_ch[i]), 64'(i));
            check("tmo_run", 64'(runs.size() > 0 ? runs[0] : 0), 64'd11);
        end
        wait_frames(2, 200);
        check("tmo_err_sticky", 64'(err_timeout), 64'd1);
        check("tmo_no_rd3_done", 64'(rd_addr.size()), 64'd6);

        // Async reset while a read is outstanding.
        for (int k = 0; k < 100 && !avm_read; k++) step();
        check("arst_read_seen", 64'(avm_read), 64'd1);
        #3 reset = 1'b1;
        #1;
        check("arst_read", 64'(avm_read), 64'd0);
        check("arst_addr", 64'(avm_address), 64'd0);
        check("arst_busy", 64'(busy), 64'd0);
        check("arst_err", 64'(err_timeout), 64'd0);
        check("arst_sample", 64'({sample_data, sample_ch, sample_valid, frame_done}), 64'd0);

        // Stop during a stalled read of slot 2, then re-enable.
        ws = 0; stuck_addr = -1; slow_addr = 2; slow_ws = 5;
        ch_mask = 6'h3F; period = 16'd50;
        do_reset();
        clear_mon();
        enable = 1'b1;
        for (int k = 0; k < 100 && !(avm_read && avm_address == 3'd2); k++) step();
        check("stop_rd2_seen", 64'(avm_read && avm_address == 3'd2), 64'd1);
        enable = 1'b0;
        repeat (20) step();
        check("stop_nsamp", 64'(samp_ch.size()), 64'd3);
        if (samp_ch.size() > 0) check("stop_last_ch", 64'(samp_ch[samp_ch.size()-1]), 64'd2);
        check("stop_no_rd3", 64'(saw_rd[3]), 64'd0);
        check("stop_no_fd", 64'(fd_cyc.size()), 64'd0);
        check("stop_busy", 64'(busy), 64'd0);
        clear_mon();
        enable = 1'b1;
        for (int k = 0; k < 20 && wr_addr.size() == 0; k++) step();
        check("reen_wr_count", 64'(wr_addr.size()), 64'd1);
        if (wr_addr.size() > 0) begin
            check("reen_wr_addr", 64'(wr_addr[0]), 64'd0);
            check("reen_wr_data", 64'(wr_dat[0]), 64'd1);
        end

        check("protocol_violations", 64'(viol), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
